// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker
//   Receive-side PRBS checker for a Fibonacci LFSR stream. It loads its local
//   LFSR from the incoming bits (HUNT) and verifies its predictions (CHECK).
//   Once locked it free-runs and counts bit errors. Too many errors inside
//   one monitoring window drop the lock, and the checker re-hunts.
//   Bit convention: state s[0:LENGTH-1], prediction p = ^(TAPS & s),
//   shift s <= {b, s[0:LENGTH-2]}.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   din_valid  in   din is sampled only when high
//   din        in   received PRBS bit
//   clr_cnt    in   synchronous clear of err_count (and bit_count)
//   locked     out  checker is synchronised
//   err_pulse  out  one-cycle pulse per erroneous bit while locked
//   lock_lost  out  one-cycle pulse when lock drops on the error threshold
//   err_count  out  saturating total error count
//   bit_count  out  saturating count of valid bits while locked
//                   (present only when PRBS_CHK_BITCNT_EN is defined)
module lfsr_prbs_checker #(
  parameter int                LENGTH     = 16,
  parameter logic [LENGTH-1:0] TAPS       = 16'h002D,
  parameter int                LOCK_CNT   = 32,
  parameter int                WINDOW     = 256,
  parameter int                ERR_THRESH = 8,
  parameter int                CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [CNT_W-1:0] bit_count
`endif
);

  localparam int FILL_W  = $clog2(LENGTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int ERR_W   = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [0:LENGTH-1]   s_q, s_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]    win_err_q, win_err_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                p;
  logic                err_hit;

  // Saturating counter update. A clear on the same cycle as an event leaves
  // the count at 1, so the event is never lost.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] cur,
                                               input logic clr,
                                               input logic inc);
    if (clr)
      return {{(CNT_W-1){1'b0}}, inc};
    else if (inc && (cur != {CNT_W{1'b1}}))
      return cur + 1'b1;
    else
      return cur;
  endfunction

  always_comb begin
    p           = ^(TAPS & s_q);
    err_hit     = din_valid && (state_q == LOCKED) && (din != p);
    state_d     = state_q;
    s_d         = s_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    lock_lost_d = 1'b0;
    err_pulse_d = err_hit;
    err_count_d = sat_cnt(err_count_q, clr_cnt, err_hit);

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          s_d = {din, s_q[0:LENGTH-2]};
          if (fill_cnt_q == FILL_W'(LENGTH - 1)) begin
            state_d     = CHECK;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          s_d = {din, s_q[0:LENGTH-2]};
          // An all-zero state predicts an all-zero stream; never count it.
          if ((din == p) && (s_q != '0)) begin
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              win_cnt_d   = '0;
              win_err_d   = '0;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so corrupted bits cannot derail us.
          s_d = {p, s_q[0:LENGTH-2]};
          if (err_hit && (win_err_q == ERR_W'(ERR_THRESH - 1))) begin
            // Threshold takes priority over a coincident window end.
            state_d     = HUNT;
            fill_cnt_d  = '0;
            lock_lost_d = 1'b1;
          end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + ERR_W'(err_hit);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HUNT;
      s_q         <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign lock_lost = lock_lost_q;
  assign err_count = err_count_q;

`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = sat_cnt(bit_count_q, clr_cnt, din_valid && (state_q == LOCKED));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bit_count_q <= '0;
    else      bit_count_q <= bit_count_d;
  end

  assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
module tb_lfsr_prbs_checker;

  localparam int          LENGTH     = 16;
  localparam logic [15:0] TAPS       = 16'h002D;
  localparam int          LOCK_CNT   = 32;
  localparam int          WINDOW     = 256;
  localparam int          ERR_THRESH = 8;
  localparam int          CNT_W      = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             din_valid;
  logic             din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic             lock_lost;
  logic [CNT_W-1:0] err_count;
`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_count;
`endif

  lfsr_prbs_checker #(
    .LENGTH(LENGTH), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW),
    .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
    .err_count(err_count)
`ifdef PRBS_CHK_BITCNT_EN
    , .bit_count(bit_count)
`endif
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  int    n_pulse;
  int    n_lost;
  string phase = "init";

  // Stimulus generator: Fibonacci LFSR, its output bit is shifted back in.
  logic [0:15] g;

  task automatic gen_next(output logic b);
    b = ^(TAPS & g);
    g = {b, g[0:14]};
  endtask

  // Reference model: a history queue of the last LENGTH bits the checker
  // holds (hist[0] newest), plus mode and counters as plain integers.
  logic             hist[$];
  int               m_mode;  // 0 hunt, 1 check, 2 locked
  int               m_fill, m_match, m_win, m_werr;
  logic             exp_locked, exp_err_pulse, exp_lock_lost;
  logic [CNT_W-1:0] exp_err_count, exp_bit_count;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < LENGTH; k++) hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    exp_locked = 0; exp_err_pulse = 0; exp_lock_lost = 0;
    exp_err_count = '0; exp_bit_count = '0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic clr);
    logic [15:0] taps_v;
    logic pred, nz, err, in_lock;
    taps_v = TAPS;
    pred = 1'b0; nz = 1'b0;
    for (int k = 0; k < LENGTH; k++) begin
      if (taps_v[LENGTH-1-k]) pred = pred ^ hist[k];
      if (hist[k]) nz = 1'b1;
    end
    in_lock = v && (m_mode == 2);
    err = in_lock && (b !== pred);
    exp_err_pulse = err;
    exp_lock_lost = 1'b0;
    if (v) begin
      if (m_mode == 0) begin
        hist.push_front(b); void'(hist.pop_back());
        m_fill++;
        if (m_fill == LENGTH) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        if (b === pred && nz) m_match++; else m_match = 0;
        hist.push_front(b); void'(hist.pop_back());
        if (m_match == LOCK_CNT) begin m_mode = 2; m_win = 0; m_werr = 0; end
      end else begin
        hist.push_front(pred); void'(hist.pop_back());
        m_win++;
        if (err) m_werr++;
        if (m_werr == ERR_THRESH) begin
          m_mode = 0; m_fill = 0; exp_lock_lost = 1'b1;
        end else if (m_win == WINDOW) begin
          m_win = 0; m_werr = 0;
        end
      end
    end
    exp_locked = (m_mode == 2);
    if (clr) exp_err_count = err ? 1 : 0;
    else if (err && exp_err_count != {CNT_W{1'b1}}) exp_err_count = exp_err_count + 1;
    if (clr) exp_bit_count = in_lock ? 1 : 0;
    else if (in_lock && exp_bit_count != {CNT_W{1'b1}}) exp_bit_count = exp_bit_count + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk({phase, ".locked"}, 64'(locked), 64'(exp_locked));
    chk({phase, ".err_pulse"}, 64'(err_pulse), 64'(exp_err_pulse));
    chk({phase, ".lock_lost"}, 64'(lock_lost), 64'(exp_lock_lost));
    chk({phase, ".err_count"}, 64'(err_count), 64'(exp_err_count));
`ifdef PRBS_CHK_BITCNT_EN
    chk({phase, ".bit_count"}, 64'(bit_count), 64'(exp_bit_count));
`endif
  endtask

  task automatic step(input logic v, input logic b, input logic clr);
    din_valid = v; din = b; clr_cnt = clr;
    model_step(v, b, clr);
    @(posedge clk); #1;
    check_all();
    if (err_pulse === 1'b1) n_pulse++;
    if (lock_lost === 1'b1) n_lost++;
  endtask

  task automatic send(input logic inv, input logic clr);
    logic gb;
    gen_next(gb);
    step(1'b1, gb ^ inv, clr);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    din_valid = 0; din = 0; clr_cnt = 0;
    rst = 1'b0;
    #1;
    chk({tag, ".rst_locked"}, 64'(locked), 64'd0);
    chk({tag, ".rst_err_pulse"}, 64'(err_pulse), 64'd0);
    chk({tag, ".rst_lock_lost"}, 64'(lock_lost), 64'd0);
    chk({tag, ".rst_err_count"}, 64'(err_count), 64'd0);
`ifdef PRBS_CHK_BITCNT_EN
    chk({tag, ".rst_bit_count"}, 64'(bit_count), 64'd0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    n_pulse = 0; n_lost = 0;
    g = 16'hACE1;
  endtask

  initial begin
    int lock_at;
    int lock_seen;
    int vcnt;
    logic r;
    rst = 1'b0; din_valid = 0; din = 0; clr_cnt = 0;
    model_reset();

    // Reset state
    do_reset("por");

    // Clean lock
    phase = "clean"; lock_at = 0;
    for (int i = 1; i <= 200; i++) begin
      send(1'b0, 1'b0);
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
    end
    chk("clean.lock_at", 64'(lock_at), 64'd48);
    chk("clean.err_count", 64'(err_count), 64'd0);
    chk("clean.pulses", 64'(n_pulse), 64'd0);

    // Single error at bit 100
    do_reset("single"); phase = "single";
    for (int i = 1; i <= 200; i++) send(i == 100, 1'b0);
    chk("single.pulses", 64'(n_pulse), 64'd1);
    chk("single.err_count", 64'(err_count), 64'd1);
    chk("single.locked", 64'(locked), 64'd1);
`ifdef PRBS_CHK_BITCNT_EN
    chk("single.bit_count", 64'(bit_count), 64'd152);
`endif

    // Burst of 8 errors, then relock
    do_reset("burst"); phase = "burst";
    for (int i = 1; i <= 67; i++) send(i >= 60, 1'b0);
    chk("burst.lock_lost", 64'(lock_lost), 64'd1);
    chk("burst.locked", 64'(locked), 64'd0);
    lock_at = 0;
    for (int j = 1; j <= 100; j++) begin
      send(1'b0, 1'b0);
      if (locked === 1'b1 && lock_at == 0) lock_at = j;
    end
    chk("burst.relock_at", 64'(lock_at), 64'd48);
    chk("burst.lost_count", 64'(n_lost), 64'd1);

    // 7 errors in each of two windows
    do_reset("subthr"); phase = "subthr";
    for (int i = 1; i <= 600; i++)
      send((i >= 100 && i <= 106) || (i >= 400 && i <= 406), 1'b0);
    chk("subthr.err_count", 64'(err_count), 64'd14);
    chk("subthr.lost", 64'(n_lost), 64'd0);
    chk("subthr.locked", 64'(locked), 64'd1);

    // clr_cnt coincident with an error, then alone
    phase = "clr";
    send(1'b1, 1'b1);
    chk("clr.with_err", 64'(err_count), 64'd1);
    send(1'b0, 1'b1);
    chk("clr.alone", 64'(err_count), 64'd0);
    chk("clr.locked", 64'(locked), 64'd1);

    // Reset while locked
    do_reset("midlock");

    // All-zero stream never locks
    phase = "zeros"; lock_seen = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked !== 1'b0) lock_seen++;
    end
    chk("zeros.lock_seen", 64'(lock_seen), 64'd0);

    // Clean stream with random valid gaps
    do_reset("gaps"); phase = "gaps"; lock_at = 0; vcnt = 0;
    for (int i = 0; i < 400 && lock_at == 0; i++) begin
      if ($urandom_range(2, 0) == 0) begin
        r = 1'($urandom);
        step(1'b0, r, 1'b0);
      end else begin
        send(1'b0, 1'b0);
        vcnt++;
      end
      if (locked === 1'b1 && lock_at == 0) lock_at = vcnt;
    end
    chk("gaps.lock_at", 64'(lock_at), 64'd48);
    chk("gaps.err_count", 64'(err_count), 64'd0);

    // Randomised errors, gaps and clears against the model
    do_reset("rand"); phase = "rand";
    for (int i = 0; i < 3000; i++) begin
      logic v, inv, clr;
      v   = ($urandom_range(3, 0) != 0);
      inv = (i < 1500) ? ($urandom_range(99, 0) == 0) : ($urandom_range(9, 0) == 0);
      clr = ($urandom_range(49, 0) == 0);
      if (v) send(inv, clr);
      else begin
        r = 1'($urandom);
        step(1'b0, r, clr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
